// File: rtl/ov5640_init_sequencer.sv
// ov5640_init_sequencer: walks the init ROM (rom_addr/rom_q) and issues each entry to the SCCB master (wr_req/wr_reg_addr/wr_data, wr_done/wr_err) with power-up wait, soft-reset settle, bounded retry and busy/init_done/init_error status; restart replays from index 0
module ov5640_init_sequencer #(
  parameter int LUT_SIZE = 91,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24,
  parameter int POWERUP_CYCLES = 1_000_000,
  parameter int RESET_WAIT_CYCLES = 250_000,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  wr_req,
  output logic [15:0]           wr_reg_addr,
  output logic [7:0]            wr_data,
  input  logic                  wr_done,
  input  logic                  wr_err,
  output logic                  busy,
  output logic                  init_done,
  output logic                  init_error
);
  localparam logic [2:0] POWERUP = 3'd0, ADDR = 3'd1, WAIT = 3'd2, REQ = 3'd3;
  localparam logic [2:0] CHECK = 3'd4, DELAY = 3'd5, DONE = 3'd6, FAIL = 3'd7;
  localparam logic [23:0] PU_LAST = 24'(POWERUP_CYCLES - 1);
  localparam logic [23:0] RW_LAST = 24'(RESET_WAIT_CYCLES - 1);
  localparam logic [7:0] MR = 8'(MAX_RETRY);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LUT_SIZE - 1);
  logic [2:0] state, nxt;
  logic [23:0] cnt;
  logic [7:0] retries;
  logic err, soft_rst, last;
  assign soft_rst = wr_reg_addr == 16'h3008 && wr_data[7];
  assign last = rom_addr == LAST;
  assign busy = state != DONE && state != FAIL;
  assign init_done = state == DONE;
  assign init_error = state == FAIL;
  always_comb begin
    nxt = state;
    case (state)
      POWERUP: nxt = cnt == PU_LAST ? ADDR : POWERUP;
      ADDR:    nxt = WAIT;
      WAIT:    nxt = REQ;
      REQ:     nxt = wr_done ? CHECK : REQ;
      CHECK:   nxt = err ? (retries < MR ? REQ : FAIL) : soft_rst ? DELAY : last ? DONE : ADDR;
      DELAY:   nxt = cnt == RW_LAST ? (last ? DONE : ADDR) : DELAY;
      default: nxt = restart ? ADDR : state;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= POWERUP;
      cnt <= '0;
      rom_addr <= '0;
      retries <= '0;
      err <= 1'b0;
      wr_req <= 1'b0;
      wr_reg_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt == state ? cnt + 24'd1 : '0;
      wr_req <= nxt == REQ;
      if (nxt == ADDR) rom_addr <= state == CHECK || state == DELAY ? rom_addr + ADDR_WIDTH'(1) : '0;
      if (state == REQ && wr_done) err <= wr_err;
      if (state == CHECK && err) retries <= retries + 8'd1;
      if (state == WAIT) begin
        wr_reg_addr <= rom_q[23:8];
        wr_data <= rom_q[7:0];
        retries <= '0;
      end
    end
endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// tb_ov5640_init_sequencer: randomized and directed bench checking the sequencer every cycle against an event-scheduling reference model
module tb_ov5640_init_sequencer;
  localparam int P = 10, R = 20, N = 4, MR = 3;
  typedef struct {int t; logic [7:0] a; logic [15:0] wa; logic [7:0] wd;} rise_t;
  logic clk = 0, reset = 1, restart = 0, wr_done = 0, wr_err = 0;
  logic wr_req, busy, init_done, init_error;
  logic [7:0] rom_addr, wr_data;
  logic [15:0] wr_reg_addr;
  logic [23:0] rom_q;
  logic [23:0] rom [N];
  int checks = 0, errors = 0;
  int cyc = 0, t_addr = -1, t_req = -1, t_end = -1, tries = 0, md;
  bit load, end_fail;
  logic e_req = 0, e_done = 0, e_err = 0;
  logic [7:0] e_addr = 0, e_wd = 0;
  logic [15:0] e_wa = 0;
  int lat_fixed = 2, emode = 0, fails2 = 0, wait_n = -1;
  bit spur = 0;
  logic prev_req = 0, prev_done = 0;
  logic [7:0] prev_addr = 0;
  rise_t rises[$];
  int achg_t[$], acks[$];
  logic [7:0] achg_a[$];
  int done_t = -1;

  ov5640_init_sequencer #(.LUT_SIZE(N), .ADDR_WIDTH(8), .DATA_WIDTH(24), .POWERUP_CYCLES(P),
    .RESET_WAIT_CYCLES(R), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .restart(restart), .rom_addr(rom_addr), .rom_q(rom_q),
    .wr_req(wr_req), .wr_reg_addr(wr_reg_addr), .wr_data(wr_data), .wr_done(wr_done),
    .wr_err(wr_err), .busy(busy), .init_done(init_done), .init_error(init_error));

  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_a(logic [7:0] a);
    int n = 0;
    foreach (rises[i]) if (rises[i].a == a) n++;
    return n;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      cyc = 0; e_addr = 0; e_req = 0; e_wa = 0; e_wd = 0; e_done = 0; e_err = 0;
      t_addr = -1; t_end = -1; t_req = P + 2; load = 1; tries = 0;
    end else begin
      cyc++;
      if (e_req && wr_done) begin
        e_req = 0;
        if (wr_err) begin
          if (tries < MR) begin tries++; t_req = cyc + 1; load = 0; end
          else begin t_end = cyc + 1; end_fail = 1; end
        end else begin
          md = (e_wa == 16'h3008 && e_wd[7]) ? R : 0;
          if (e_addr == N - 1) begin t_end = cyc + 1 + md; end_fail = 0; end
          else begin t_addr = cyc + 1 + md; t_req = cyc + 3 + md; load = 1; end
        end
      end else if (restart && (e_done || e_err)) begin
        e_done = 0; e_err = 0; e_addr = 0; t_req = cyc + 2; load = 1;
      end
      if (cyc == t_addr) e_addr++;
      if (cyc == t_req) begin
        e_req = 1;
        if (load) begin
          e_wa = rom[e_addr[1:0]][23:8];
          e_wd = rom[e_addr[1:0]][7:0];
          tries = 0;
        end
      end
      if (cyc == t_end) begin
        if (end_fail) e_err = 1;
        else e_done = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("wr_req", 32'(wr_req), 32'(e_req));
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
    chk("wr_reg_addr", 32'(wr_reg_addr), 32'(e_wa));
    chk("wr_data", 32'(wr_data), 32'(e_wd));
    chk("init_done", 32'(init_done), 32'(e_done));
    chk("init_error", 32'(init_error), 32'(e_err));
    chk("busy", 32'(busy), 32'(!(e_done || e_err)));
    if (wr_req && !prev_req) rises.push_back('{cyc, rom_addr, wr_reg_addr, wr_data});
    if (rom_addr != prev_addr) begin achg_t.push_back(cyc); achg_a.push_back(rom_addr); end
    if (init_done && !prev_done) done_t = cyc;
    prev_req = wr_req; prev_addr = rom_addr; prev_done = init_done;
    wr_done = 0; wr_err = 0;
    if (reset) wait_n = -1;
    else if (wr_req) begin
      if (wait_n < 0) wait_n = lat_fixed >= 0 ? lat_fixed : int'($urandom_range(0, 3));
      if (wait_n == 0) begin
        wr_done = 1; wait_n = -1; acks.push_back(cyc + 1);
        case (emode)
          1: wr_err = $urandom_range(0, 3) == 0;
          2: begin wr_err = rom_addr == 2 && fails2 < 2; if (wr_err) fails2++; end
          3: wr_err = rom_addr == 2;
          default: wr_err = 0;
        endcase
      end else wait_n--;
    end else begin
      wait_n = -1;
      if (spur && $urandom_range(0, 5) == 0) begin wr_done = 1; wr_err = 1'($urandom_range(0, 1)); end
    end
  end

  task automatic release_reset();
    repeat (3) @(negedge clk);
    #2;
    rises.delete(); achg_t.delete(); achg_a.delete(); acks.delete(); done_t = -1; fails2 = 0;
    reset = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1;
    release_reset();
  endtask

  task automatic wait_idle(int limit, bit rnd);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      if (rnd) restart = $urandom_range(0, 19) == 0;
      n++;
    end
    restart = 0;
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int rt, t1, n;
    rom = '{24'h1234_56, 24'h3100_78, 24'h4300_9a, 24'h5000_bc};
    do_reset();
    wait_idle(500, 0);
    chk("req_count", rises.size(), 4);
    chk("first_req_t", rises.size() > 0 ? rises[0].t : -1, 12);
    foreach (rises[i]) begin
      chk("order_addr", 32'(rises[i].a), i);
      chk("order_reg", 32'(rises[i].wa), 32'(rom[i][23:8]));
      chk("order_data", 32'(rises[i].wd), 32'(rom[i][7:0]));
    end
    chk("done_t", done_t, acks.size() > 0 ? acks[$] + 1 : -1);
    chk("done_flag", 32'(init_done), 1);
    rt = cyc + 1;
    rises.delete();
    restart = 1;
    @(negedge clk);
    restart = 0;
    chk("restart_drop", 32'(init_done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_addr", 32'(rom_addr), 0);
    wait_idle(500, 0);
    chk("replay_first_t", rises.size() > 0 ? rises[0].t : -1, rt + 2);
    chk("replay_count", rises.size(), 4);
    for (int k = 0; k < 2; k++) begin
      rom[0] = k == 0 ? 24'h3008_82 : 24'h3008_02;
      do_reset();
      wait_idle(500, 0);
      t1 = -1;
      foreach (achg_t[i]) if (achg_a[i] == 1 && t1 < 0) t1 = achg_t[i];
      chk(k == 0 ? "softreset_gap" : "no_gap", t1 - (acks.size() > 0 ? acks[0] : 0), k == 0 ? 1 + R : 1);
      chk("soft_done", 32'(init_done), 1);
    end
    rom[0] = 24'h1234_56;
    emode = 2;
    do_reset();
    wait_idle(500, 0);
    chk("retry_reqs", count_a(2), 3);
    foreach (rises[i]) if (rises[i].a == 2) begin
      chk("retry_reg", 32'(rises[i].wa), 32'(rom[2][23:8]));
      chk("retry_data", 32'(rises[i].wd), 32'(rom[2][7:0]));
    end
    chk("retry_next", count_a(3), 1);
    chk("retry_done", 32'(init_done), 1);
    emode = 3;
    do_reset();
    wait_idle(500, 0);
    chk("fail_reqs", count_a(2), 4);
    chk("fail_flag", 32'(init_error), 1);
    chk("fail_addr", 32'(rom_addr), 2);
    n = rises.size();
    repeat (50) @(negedge clk);
    chk("fail_quiet", rises.size(), n);
    chk("fail_no_entry3", count_a(3), 0);
    emode = 0;
    do_reset();
    repeat (4) @(negedge clk);
    restart = 1;
    @(negedge clk);
    restart = 0;
    n = 0;
    while (!wr_req && n < 100) begin @(negedge clk); n++; end
    restart = 1;
    @(negedge clk);
    restart = 0;
    wait_idle(500, 0);
    chk("midrestart_first_t", rises.size() > 0 ? rises[0].t : -1, 12);
    chk("midrestart_count", rises.size(), 4);
    do_reset();
    n = 0;
    while (!wr_req && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #2;
    chk("pre_reset_req", 32'(wr_req), 1);
    reset = 1;
    #1;
    chk("async_req", 32'(wr_req), 0);
    chk("async_addr", 32'(rom_addr), 0);
    chk("async_reg", 32'(wr_reg_addr), 0);
    chk("async_data", 32'(wr_data), 0);
    chk("async_busy", 32'(busy), 1);
    release_reset();
    wait_idle(500, 0);
    chk("rerun_first_t", rises.size() > 0 ? rises[0].t : -1, 12);
    emode = 1; spur = 1; lat_fixed = -1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        rom[i] = $urandom_range(0, 2) == 0 ? {16'h3008, 8'($urandom)} : 24'($urandom);
      do_reset();
      for (int k = 0; k < 2; k++) begin
        wait_idle(3000, 1);
        @(negedge clk);
        restart = 1;
        @(negedge clk);
        restart = 0;
      end
      wait_idle(3000, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
